// File: rtl/fourbit_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fourbit_div_pkg
//  Purpose  : Shared types and constants for the sequential restoring divider.
//             - state_t        : FSM state encoding (IDLE / RUN / DONE)
//             - DW_DEF, VW_DEF : default dividend / divisor widths
//             - CNT_W          : iteration counter width for the default DW
//             - C_DBZ_QUOTIENT : quotient reported on divide-by-zero
//  Revision : 1.0 - initial release
// ============================================================================
package fourbit_div_pkg;

    localparam int DW_DEF = 8;
    localparam int VW_DEF = 4;
    localparam int CNT_W  = $clog2(DW_DEF);

    // Divide-by-zero saturates the quotient to all ones.
    localparam logic [DW_DEF-1:0] C_DBZ_QUOTIENT = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage : fourbit_div_pkg
`default_nettype wire

// File: rtl/fourbit_div_if.sv
`default_nettype none
// ============================================================================
//  Module   : fourbit_div_if
//  Purpose  : Start/done handshake and operand/result bus of the divider.
//             master : drives start, dividend, divisor; observes results
//             slave  : the divider side
//             start, dividend[DW], divisor[VW]            -> divider
//             busy, done, quotient[DW], remainder[VW],
//             div_by_zero                                 <- divider
//  Revision : 1.0 - initial release
// ============================================================================
interface fourbit_div_if #(
    parameter int DW = fourbit_div_pkg::DW_DEF,
    parameter int VW = fourbit_div_pkg::VW_DEF
);

    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface : fourbit_div_if
`default_nettype wire

// File: rtl/fourbit_div_step.sv
`default_nettype none
// ============================================================================
//  Module   : fourbit_div_step
//  Purpose  : One combinational restoring-division step.
//             i_p    [VW+1] : partial remainder before the step
//             i_bit  [1]    : next dividend bit shifted in
//             i_d    [VW]   : divisor
//             o_p    [VW+1] : partial remainder after the step
//             o_qbit [1]    : resolved quotient bit
//  Revision : 1.0 - initial release
// ============================================================================
module fourbit_div_step #(
    parameter int VW = fourbit_div_pkg::VW_DEF
) (
    input  wire logic [VW:0]   i_p,
    input  wire logic          i_bit,
    input  wire logic [VW-1:0] i_d,
    output logic      [VW:0]   o_p,
    output logic               o_qbit
);

    logic [VW:0] w_t;
    logic [VW:0] w_d_ext;

    // The incoming partial remainder is always below the divisor, so its
    // MSB is zero and only the low VW bits take part in the shift.
    logic w_unused_p_msb;
    assign w_unused_p_msb = i_p[VW];

    assign w_t     = {i_p[VW-1:0], i_bit};
    assign w_d_ext = {1'b0, i_d};

    always_comb begin
        o_qbit = 1'b0;
        o_p    = w_t;
        if (w_t >= w_d_ext) begin
            o_qbit = 1'b1;
            o_p    = w_t - w_d_ext;
        end
    end

endmodule : fourbit_div_step
`default_nettype wire

// File: rtl/fourbit_div.sv
`default_nettype none
// ============================================================================
//  Module   : fourbit_div
//  Purpose  : Sequential restoring divider, one quotient bit per clock.
//             Returns floor(dividend/divisor) and dividend mod divisor DW
//             cycles after an accepted start; a zero divisor finishes in one
//             cycle with an all-ones quotient and div_by_zero set.
//             clk  : rising-edge clock
//             rst  : synchronous active-high reset
//             bus  : fourbit_div_if.slave (start/operands in, results out)
//  Revision : 1.0 - initial release
// ============================================================================
module fourbit_div
    import fourbit_div_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int VW = VW_DEF
) (
    input wire logic     clk,
    input wire logic     rst,
    fourbit_div_if.slave bus
);

    localparam int C_CNT_W = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(DW - 1);

    state_t               r_state;
    state_t               w_state_next;

    logic [DW-1:0]        r_q_sh;
    logic [VW-1:0]        r_d;
    logic [VW:0]          r_p;
    logic [C_CNT_W-1:0]   r_count;
    logic [DW-1:0]        r_quotient;
    logic [VW-1:0]        r_remainder;
    logic                 r_dbz;

    logic [VW:0]          w_step_p;
    logic                 w_qbit;
    logic                 w_last;
    logic                 w_accept;
    logic                 w_zero_div;
    logic                 w_busy;
    logic                 w_done;

    assign w_accept   = (r_state == S_IDLE) && bus.start;
    assign w_zero_div = (bus.divisor == '0);
    assign w_last     = (r_count == C_LAST);

    fourbit_div_step #(
        .VW (VW)
    ) u_step (
        .i_p    (r_p),
        .i_bit  (r_q_sh[DW-1]),
        .i_d    (r_d),
        .o_p    (w_step_p),
        .o_qbit (w_qbit)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_next = w_zero_div ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_RUN:  w_busy = 1'b1;
            S_DONE: begin
                w_busy = 1'b1;
                w_done = 1'b1;
            end
            default: begin
                w_busy = 1'b0;
                w_done = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand capture, iteration, result registers.
    // Results only change on entry to DONE (or div_by_zero clearing on an
    // accepted non-zero start), so they stay readable between operations.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q_sh      <= '0;
            r_d         <= '0;
            r_p         <= '0;
            r_count     <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            if (w_accept) begin
                if (w_zero_div) begin
                    r_quotient  <= '1;
                    r_remainder <= bus.dividend[VW-1:0];
                    r_dbz       <= 1'b1;
                end else begin
                    r_q_sh  <= bus.dividend;
                    r_d     <= bus.divisor;
                    r_p     <= '0;
                    r_count <= '0;
                    r_dbz   <= 1'b0;
                end
            end else if (r_state == S_RUN) begin
                r_p     <= w_step_p;
                r_q_sh  <= {r_q_sh[DW-2:0], w_qbit};
                r_count <= r_count + C_CNT_W'(1);
                if (w_last) begin
                    r_quotient  <= {r_q_sh[DW-2:0], w_qbit};
                    r_remainder <= w_step_p[VW-1:0];
                end
            end
        end
    end

    assign bus.busy        = w_busy;
    assign bus.done        = w_done;
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_dbz;

endmodule : fourbit_div
`default_nettype wire

// File: tb/tb_fourbit_div.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fourbit_div
//  Purpose  : Self-checking bench for fourbit_div. Expected results come from
//             integer / and % on the operands; latency, done pulse width,
//             busy and result hold behaviour are checked against fixed rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fourbit_div;

    localparam int DW = 8;
    localparam int VW = 4;

    logic clk;
    logic rst;

    int n_checks;
    int n_pass;

    // Last results the model expects the DUT to be holding.
    int m_q;
    int m_r;

    fourbit_div_if #(.DW(DW), .VW(VW)) bus ();

    fourbit_div #(
        .DW (DW),
        .VW (VW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation: start, wait for done, check, then the DONE->IDLE
    // edge. With poke set, extra starts (50/5) are offered mid-RUN and in
    // DONE; both must be ignored.
    task automatic run_div(input int a, input int b, input bit poke);
        int  exp_q, exp_r, exp_z, exp_lat, lat;
        bit  held;
        bit  busy_ok;
        string op;
        op = $sformatf("%0d/%0d", a, b);
        if (b == 0) begin
            exp_q = 255; exp_r = a % 16; exp_z = 1; exp_lat = 0;
        end else begin
            exp_q = a / b; exp_r = a % b; exp_z = 0; exp_lat = DW;
        end

        bus.start    = 1'b1;
        bus.dividend = DW'(a);
        bus.divisor  = VW'(b);
        tick();
        bus.start    = 1'b0;
        bus.dividend = DW'($urandom);
        bus.divisor  = VW'($urandom);

        lat = 0; held = 1'b1; busy_ok = 1'b1;
        while (!bus.done && lat < 20) begin
            if (int'(bus.quotient) != m_q || int'(bus.remainder) != m_r) held = 1'b0;
            if (!bus.busy) busy_ok = 1'b0;
            if (poke && lat == 2) begin
                bus.start = 1'b1; bus.dividend = 8'd50; bus.divisor = 4'd5;
            end else begin
                bus.start = 1'b0;
            end
            tick();
            lat++;
        end
        bus.start = 1'b0;

        check({"latency ", op}, lat, exp_lat);
        check({"quotient ", op}, int'(bus.quotient), exp_q);
        check({"remainder ", op}, int'(bus.remainder), exp_r);
        check({"div_by_zero ", op}, int'(bus.div_by_zero), exp_z);
        check({"busy at done ", op}, int'(bus.busy), 1);
        if (b != 0) begin
            check({"hold+busy in run ", op}, int'(held && busy_ok), 1);
        end
        m_q = exp_q;
        m_r = exp_r;

        if (poke) begin
            bus.start = 1'b1; bus.dividend = 8'd50; bus.divisor = 4'd5;
        end
        tick();
        bus.start = 1'b0;
        check({"done pulse ", op}, int'(bus.done), 0);
        check({"busy idle ", op}, int'(bus.busy), 0);
        if (poke) begin
            tick();
            check({"start not queued ", op}, int'(bus.busy), 0);
            check({"results hold ", op}, int'(bus.quotient) * 16 + int'(bus.remainder),
                  m_q * 16 + m_r);
        end
    endtask

    initial begin
        int  lat;
        bit  saw_done;
        n_checks = 0; n_pass = 0;
        m_q = 0; m_r = 0;
        rst = 1'b1;
        bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
        tick(); tick();
        rst = 1'b0;

        check("reset busy",        int'(bus.busy), 0);
        check("reset done",        int'(bus.done), 0);
        check("reset quotient",    int'(bus.quotient), 0);
        check("reset remainder",   int'(bus.remainder), 0);
        check("reset div_by_zero", int'(bus.div_by_zero), 0);

        run_div(200, 7, 1'b0);
        run_div(255, 15, 1'b0);
        run_div(5, 9, 1'b0);
        run_div(8'hB3, 0, 1'b0);
        run_div(100, 3, 1'b1);

        // Reset mid-operation: start 200/7, reset after 3 RUN edges.
        bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 4'd7;
        tick();
        bus.start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort busy",        int'(bus.busy), 0);
        check("abort done",        int'(bus.done), 0);
        check("abort quotient",    int'(bus.quotient), 0);
        check("abort remainder",   int'(bus.remainder), 0);
        check("abort div_by_zero", int'(bus.div_by_zero), 0);
        m_q = 0; m_r = 0;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.done) saw_done = 1'b1;
        end
        check("abort no done", int'(saw_done), 0);
        run_div(9, 2, 1'b0);

        // Randomized operands, zero divisors included.
        for (int i = 0; i < 200; i++) begin
            run_div(int'($urandom_range(255, 0)), int'($urandom_range(15, 0)), 1'b0);
        end

        // Exhaustive sweep of all non-zero divisors, back to back.
        for (int a = 0; a < 256; a++) begin
            for (int b = 1; b < 16; b++) begin
                run_div(a, b, 1'b0);
            end
        end

        lat = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_fourbit_div
`default_nettype wire

// File: doc/fourbit_div.md
Name: fourbit_div

Overview:
- Sequential restoring divider; the inverse of the combinational 4-bit multiplier in the Flag Vending Machine datapath.
- Takes an 8-bit dividend (for example, a multiplier product) and a 4-bit divisor. Returns quotient and remainder after a fixed number of cycles.
- Start/done handshake; one quotient bit resolved per clock.

Parameters:
- DW, 8, dividend and quotient width
- VW, 4, divisor and remainder width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request; sampled only in IDLE
- dividend  in  DW  numerator; captured on accepted start
- divisor  in  VW  denominator; captured on accepted start
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse; results valid
- quotient  out  DW  floor(dividend/divisor)
- remainder  out  VW  dividend mod divisor
- div_by_zero  out  1  set when captured divisor was 0

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Reset values: state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, count=0.
- States:
  - IDLE: wait for start.
  - RUN: DW iterations.
  - DONE: single cycle.
- IDLE->RUN: on edge k with start=1 and divisor!=0.
  - Capture dividend into shift register q_sh and divisor into d_r.
  - Clear partial remainder p (VW+1 bits) to 0; clear count; div_by_zero<=0.
- IDLE->DONE (divide by zero): on edge k with start=1 and divisor==0.
  - quotient<=all ones; remainder<=dividend[VW-1:0]; div_by_zero<=1.
  - done=1 after edge k; no RUN cycles.
- RUN step, each edge:
  - t = {p[VW-1:0], q_sh[DW-1]}.
  - If t >= d_r: p<=t-d_r, new q bit 1. Else p<=t, q bit 0.
  - q_sh <= {q_sh[DW-2:0], qbit}; count++.
- RUN->DONE: on the edge where count==DW-1, i.e. the DW-th RUN edge (edge k+DW).
  - That edge loads quotient and remainder from the final step values.
  - done=1 after edge k+DW; latency DW cycles from start sample (8 by default).
- DONE->IDLE: unconditional next edge; done returns to 0.
- Output hold: quotient, remainder and div_by_zero hold their values until the next accepted start. They do not change during a following RUN; they update only on entry to DONE.
- Start outside IDLE: start during RUN or DONE is ignored, not queued. Inputs may change freely while busy.
- Back-to-back: the earliest next accept is the IDLE cycle after DONE, giving throughput 1 result per DW+2 cycles.
- rst mid-operation: return to the reset values on that edge; no done pulse for the aborted operation.
- Width rules:
  - p is VW+1 bits so the t>=d_r compare never overflows.
  - Final remainder is p[VW-1:0], always < divisor.
  - quotient <= dividend, no saturation except the div-by-zero rule.

Decomposition:
- Package fourbit_div_pkg:
  - state enum {S_IDLE, S_RUN, S_DONE}.
  - Width constants DW_DEF=8, VW_DEF=4.
  - CNT_W = $clog2(DW).
  - div-by-zero quotient constant (all ones).
- Sub-module div_step: combinational single restoring step.
  - Inputs: p, incoming bit, d.
  - Outputs: next p, qbit.
- Top module holds the FSM, counter and registers.

Test Plan:
- rst, then start with dividend=200, divisor=7 -> done exactly 8 cycles after start sample; quotient=28, remainder=4, div_by_zero=0.
- dividend=255, divisor=15 -> quotient=17, remainder=0. Then dividend=5, divisor=9 -> quotient=0, remainder=5.
- dividend=0xB3, divisor=0 -> done 1 cycle after start; quotient=0xFF, remainder=3, div_by_zero=1, busy high for 1 cycle.
- Start 100/3, then pulse start with 50/5 at cycles 3 and 8 (DONE) -> only 33 r1 reported, a single done pulse; both extra starts ignored.
- Start 200/7, assert rst at cycle 4 -> all outputs 0 next cycle, no done. Then start 9/2 -> quotient=4, remainder=1.
- Exhaustive sweep of all 256×15 nonzero pairs, back-to-back -> every result matches integer / and %. Results hold steady between done pulses.
